// File: rtl/button_event_decoder.sv
// ============================================================================
//  Module   : button_event_decoder
//  Purpose  : Turns a debounced switch level into one-cycle gesture events:
//             short press, long press and double press. o_busy is high
//             whenever a gesture is in progress.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_event_decoder #(
  parameter int LONG_LIMIT = 12500000,
  parameter int GAP_LIMIT  = 6250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_switch,
  output logic o_short,
  output logic o_long,
  output logic o_double,
  output logic o_busy
);

  // One counter serves both the hold timer and the gap timer, so it is sized
  // for the larger of the two limits.
  localparam int MAX_LIMIT = (LONG_LIMIT > GAP_LIMIT) ? LONG_LIMIT : GAP_LIMIT;
  localparam int CNT_W     = $clog2(MAX_LIMIT);

  // Terminal counts. The counter is compared against these before it is
  // incremented, so it never needs to hold LIMIT itself and never wraps.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_LIMIT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LIMIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HELD = 3'd2,
    WAIT_GAP  = 3'd3,
    PRESS2    = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] count_nxt;
  logic             short_nxt;
  logic             long_nxt;
  logic             double_nxt;

  // State, counter and registered event outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      r_count  <= '0;
      o_short  <= 1'b0;
      o_long   <= 1'b0;
      o_double <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      state    <= state_nxt;
      r_count  <= count_nxt;
      o_short  <= short_nxt;
      o_long   <= long_nxt;
      o_double <= double_nxt;
      o_busy   <= (state_nxt != IDLE);
    end
  end

  // Next-state, counter and event decode. Level changes are checked before
  // the thresholds, so a release or press always beats a simultaneous timeout.
  always_comb begin
    state_nxt  = state;
    count_nxt  = r_count;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (i_switch) begin
          state_nxt = PRESS1;
          count_nxt = '0;
        end
      end

      PRESS1: begin
        if (!i_switch) begin
          state_nxt = WAIT_GAP;
          count_nxt = '0;
        end else if (r_count == LONG_LAST) begin
          long_nxt  = 1'b1;
          state_nxt = LONG_HELD;
          count_nxt = '0;
        end else begin
          count_nxt = r_count + CNT_W'(1);
        end
      end

      LONG_HELD: begin
        if (!i_switch) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      end

      WAIT_GAP: begin
        if (i_switch) begin
          state_nxt = PRESS2;
          count_nxt = '0;
        end else if (r_count == GAP_LAST) begin
          short_nxt = 1'b1;
          state_nxt = IDLE;
          count_nxt = '0;
        end else begin
          count_nxt = r_count + CNT_W'(1);
        end
      end

      PRESS2: begin
        if (!i_switch) begin
          double_nxt = 1'b1;
          state_nxt  = IDLE;
          count_nxt  = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

endmodule

`default_nettype wire
